// File: rtl/seq_alu.sv
// seq_alu: multi-cycle 8-bit execution unit between the register-file read ports
// and writeback. Single-cycle ADD/SUB/AND/XOR/PASSB, shifts iterate one bit per
// cycle, optional shift-add MUL over 8 cycles.
// Configuration macro: SEQ_ALU_MUL_EN (defined = multiplier present; undefined =
// op 110 completes in one cycle with result 0, carry 0).
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, op, datA/B   request, opcode and operands (sampled when accepted)
//   result, carry, zero registered result and flags, updated only on done
//   busy                operation in flight
//   done                one-cycle completion pulse (writeback enable)
module seq_alu #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] datA,
    input  logic [W-1:0] datB,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [2:0]       k_q;
    logic [W-1:0]     acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             active;
    logic [2:0]       s_op;
    logic [2:0]       s_k;
    logic [W-1:0]     s_acc;
    logic [CNT_W-1:0] s_cnt;
    logic [W-1:0]     n_acc;
    logic             n_cout;
    logic [CNT_W-1:0] n_cnt;
    logic [CNT_W-1:0] lat;
    logic             last;
    logic [W:0]       sum_ab;
    logic [W-1:0]     fin_res;
    logic             fin_c;

`ifdef SEQ_ALU_MUL_EN
    logic [W-1:0] a_q;
    logic [W-1:0] hi_q;
    logic [W-1:0] s_a;
    logic [W-1:0] s_hi;
    logic [W-1:0] n_hi;
    logic [W:0]   psum;
`endif

    // Iteration step: on an accepted start the operands feed the step directly,
    // so the accept edge is itself the first iteration.
    always_comb begin
        accept = start && (state == S_IDLE);
        active = accept || (state == S_RUN);
        s_op   = accept ? op : op_q;
        s_k    = accept ? datB[2:0] : k_q;
        s_cnt  = accept ? '0 : cnt_q;
        s_acc  = accept ? ((op == OP_MUL) ? datB : datA) : acc_q;
        n_acc  = s_acc;
        n_cout = 1'b0;
        n_cnt  = s_cnt + CNT_W'(1);
`ifdef SEQ_ALU_MUL_EN
        s_a  = accept ? datA : a_q;
        s_hi = accept ? '0 : hi_q;
        // {hi, acc} acts as one product register; acc starts as the multiplier
        psum = {1'b0, s_hi} + (s_acc[0] ? {1'b0, s_a} : '0);
        n_hi = psum[W:1];
`endif
        lat = CNT_W'(1);
        case (s_op)
            OP_SHL: begin
                n_acc  = {s_acc[W-2:0], 1'b0};
                n_cout = s_acc[W-1];
                lat    = (s_k == 3'd0) ? CNT_W'(1) : CNT_W'(s_k);
            end
            OP_SHR: begin
                n_acc  = {1'b0, s_acc[W-1:1]};
                n_cout = s_acc[0];
                lat    = (s_k == 3'd0) ? CNT_W'(1) : CNT_W'(s_k);
            end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin
                n_acc = {psum[0], s_acc[W-1:1]};
                lat   = CNT_W'(8);
            end
`endif
            default: ;
        endcase
        last = (n_cnt == lat);
    end

    // Final result and carry; single-cycle ops only finish on the accept edge,
    // so they read the live operands.
    always_comb begin
        sum_ab  = {1'b0, datA} + {1'b0, datB};
        fin_res = '0;
        fin_c   = 1'b0;
        case (s_op)
            OP_ADD: begin
                fin_res = sum_ab[W-1:0];
                fin_c   = sum_ab[W];
            end
            OP_SUB: begin
                fin_res = datA - datB;
                fin_c   = (datA >= datB);
            end
            OP_AND:   fin_res = datA & datB;
            OP_XOR:   fin_res = datA ^ datB;
            OP_PASSB: fin_res = datB;
            OP_SHL, OP_SHR: begin
                if (s_k == 3'd0) begin
                    fin_res = datA;
                end else begin
                    fin_res = n_acc;
                    fin_c   = n_cout;
                end
            end
            OP_MUL: begin
`ifdef SEQ_ALU_MUL_EN
                fin_res = n_acc;
                fin_c   = |n_hi;
`endif
            end
            default: ;
        endcase
    end

    // State, working registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            op_q   <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            a_q    <= '0;
            hi_q   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (active) begin
                op_q  <= s_op;
                k_q   <= s_k;
                acc_q <= n_acc;
                cnt_q <= n_cnt;
`ifdef SEQ_ALU_MUL_EN
                a_q   <= s_a;
                hi_q  <= n_hi;
`endif
                if (last) begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    result <= fin_res;
                    carry  <= fin_c;
                    zero   <= (fin_res == '0);
                end else begin
                    state <= S_RUN;
                    busy  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized back-to-back
// operations checked against an arithmetic reference model.
module tb_seq_alu;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] datA;
    logic [7:0] datB;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    logic [7:0] held_res = 8'h00;

    seq_alu #(.W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .datA(datA), .datB(datB), .result(result), .carry(carry),
        .zero(zero), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model straight from the arithmetic definition of each op
    function automatic void model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output int lat);
        int k;
        int p;
        k = int'(b[2:0]);
        lat = 1;
        c = 1'b0;
        case (o)
            3'd0: begin p = int'(a) + int'(b); r = 8'(p % 256); c = (p >= 256); end
            3'd1: begin p = int'(a) - int'(b) + 256; r = 8'(p % 256); c = (a >= b); end
            3'd2: r = a & b;
            3'd3: r = a ^ b;
            3'd4: begin
                p = int'(a) * (1 << k);
                r = 8'(p % 256);
                if (k != 0) begin c = ((int'(a) >> (8 - k)) & 1) == 1; lat = k; end
            end
            3'd5: begin
                r = 8'(int'(a) >> k);
                if (k != 0) begin c = ((int'(a) >> (k - 1)) & 1) == 1; lat = k; end
            end
            3'd6: begin
`ifdef SEQ_ALU_MUL_EN
                p = int'(a) * int'(b);
                r = 8'(p % 256);
                c = (p >= 256);
                lat = 8;
`else
                r = 8'h00;
`endif
            end
            default: r = b;
        endcase
    endfunction

    // Present an operation and step past the edge that accepts it (ends in cycle 1)
    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        op = o; datA = a; datB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom); datA = 8'($urandom); datB = 8'($urandom);
    endtask

    // Follow an issued op through cycles 1..L; optionally pulse start at cycle inj
    task automatic check_op(input string nm, input logic [2:0] o, input logic [7:0] a,
                            input logic [7:0] b, input int inj);
        logic [7:0] er;
        logic ec;
        int lat;
        model(o, a, b, er, ec, lat);
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == inj + 1) start = 1'b0;
            checks++;
            if (done !== 1'(c == lat)) begin errors++;
                $display("FAIL %s done cyc%0d: got %b want %b", nm, c, done, c == lat); end
            checks++;
            if (busy !== 1'(c < lat)) begin errors++;
                $display("FAIL %s busy cyc%0d: got %b want %b", nm, c, busy, c < lat); end
            if (c < lat) begin
                checks++;
                if (result !== held_res) begin errors++;
                    $display("FAIL %s hold cyc%0d: got %h want %h", nm, c, result, held_res); end
            end
            if (c == inj && c < lat) begin
                start = 1'b1; op = 3'd0; datA = 8'($urandom); datB = 8'($urandom);
            end
        end
        checks++;
        if (result !== er) begin errors++;
            $display("FAIL %s result: got %h want %h", nm, result, er); end
        checks++;
        if (carry !== ec) begin errors++;
            $display("FAIL %s carry: got %b want %b", nm, carry, ec); end
        checks++;
        if (zero !== (er == 8'h00)) begin errors++;
            $display("FAIL %s zero: got %b want %b", nm, zero, er == 8'h00); end
        held_res = er;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 3'd0; datA = 8'h12; datB = 8'h34;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset result: got %h want 00", result); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset carry: got %b want 0", carry); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset zero: got %b want 0", zero); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        reset = 1'b0;
        held_res = 8'h00;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_idle done: got %b want 0", done); end
    endtask

    task automatic test_directed();
        issue(3'd0, 8'hF0, 8'h20); check_op("add_carry", 3'd0, 8'hF0, 8'h20, -1);
        issue(3'd1, 8'h05, 8'h05); check_op("sub_zero",  3'd1, 8'h05, 8'h05, -1);
        issue(3'd1, 8'h03, 8'h05); check_op("sub_borrow", 3'd1, 8'h03, 8'h05, -1);
        issue(3'd5, 8'h81, 8'h01); check_op("shr_k1",    3'd5, 8'h81, 8'h01, -1);
        issue(3'd4, 8'h81, 8'h03); check_op("shl_k3",    3'd4, 8'h81, 8'h03, -1);
        issue(3'd4, 8'h81, 8'h08); check_op("shl_k0",    3'd4, 8'h81, 8'h08, -1);
        issue(3'd2, 8'h3C, 8'h0F); check_op("and",       3'd2, 8'h3C, 8'h0F, -1);
        issue(3'd3, 8'hAA, 8'hAA); check_op("xor_zero",  3'd3, 8'hAA, 8'hAA, -1);
        issue(3'd7, 8'h11, 8'h5A); check_op("passb",     3'd7, 8'h11, 8'h5A, -1);
        issue(3'd5, 8'h80, 8'h07); check_op("shr_k7",    3'd5, 8'h80, 8'h07, -1);
    endtask

    task automatic test_mul_ignore();
        issue(3'd6, 8'h10, 8'h11); check_op("mul_ign", 3'd6, 8'h10, 8'h11, 3);
        issue(3'd0, 8'h01, 8'h01); check_op("b2b_add", 3'd0, 8'h01, 8'h01, -1);
        issue(3'd6, 8'hFF, 8'hFF); check_op("mul_max", 3'd6, 8'hFF, 8'hFF, -1);
    endtask

    task automatic test_reset_mid();
        logic [2:0] o;
`ifdef SEQ_ALU_MUL_EN
        o = 3'd6;
`else
        o = 3'd4;
`endif
        issue(o, 8'h10, 8'h17);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b want 0", busy); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL rstmid result: got %h want 00", result); end
        checks++; if ({carry, zero, done} !== 3'b000) begin errors++;
            $display("FAIL rstmid flags: got %b want 000", {carry, zero, done}); end
        held_res = 8'h00;
        for (int c = 6; c <= 12; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin errors++;
                $display("FAIL rstmid quiet cyc%0d: got done=%b busy=%b want 0 0", c, done, busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] o;
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            issue(o, a, b);
            check_op("rand", o, a, b, (i % 5 == 0) ? 1 : -1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                checks++;
                if (done !== 1'b0 || result !== held_res) begin errors++;
                    $display("FAIL idle_hold: got done=%b res=%h want 0 %h", done, result, held_res); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; datA = 8'h00; datB = 8'h00;
        test_reset();
        test_directed();
        test_mul_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
